pipe_stage_skid: RTL

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage with enable, flush and synchronous reset.
// Define PIPE_STAGE_SKID_STATS_EN to add the saturating stall_cnt output.
module pipe_stage_skid #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_STAGE_SKID_STATS_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    // in_ready depends only on en and the registered state, never on out_ready
    assign in_ready  = en && (state_q != FULL);
    assign out_valid = en && (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : NOP;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // State and payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and payload steering; transfers are already gated by en
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_STATS_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles where upstream offered a beat that was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_valid && !in_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule
